// File: rtl/percept_bus_master.sv
// Host-side initiator for the single-wire perceptron front-end bus: serialises
// read/write requests into 74-bit frames and deserialises 64-bit read replies.
module percept_bus_master #(
    parameter int RD_LAT   = 0,
    parameter int IDLE_GAP = 2
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [7:0]  req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        busy,
    output logic        ser_out,
    input  logic        ser_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_CMD,
        S_DATA,
        S_TAIL,
        S_GAP
    } state_t;

    localparam logic HAS_TAIL = (RD_LAT > 0);

    state_t      r_state;
    logic [6:0]  r_cnt;
    logic        r_write;
    logic [7:0]  r_addrSh;
    logic [63:0] r_dataSh;
    logic [63:0] r_capSh;
    logic        r_serOut;
    logic        r_rspValid;
    logic [63:0] r_rspData;

    logic        w_accept;
    logic        w_capture;
    logic [63:0] w_capNext;

    assign req_ready = (r_state == S_IDLE);
    assign busy      = ~req_ready;
    assign ser_out   = r_serOut;
    assign rsp_valid = r_rspValid;
    assign rsp_rdata = r_rspData;

    assign w_accept  = req_valid && req_ready;
    // Capturing on every DATA/TAIL edge of a read lets the first RD_LAT
    // (not yet valid) samples fall off the top of the 64-bit shifter.
    assign w_capture = !r_write && ((r_state == S_DATA) || (r_state == S_TAIL));
    assign w_capNext = {r_capSh[62:0], ser_in};

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_addrSh   <= '0;
            r_dataSh   <= '0;
            r_capSh    <= '0;
            r_serOut   <= 1'b1;
            r_rspValid <= 1'b0;
            r_rspData  <= '0;
        end else begin
            r_rspValid <= 1'b0;
            if (w_capture) begin
                r_capSh <= w_capNext;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_START;
                        r_write  <= req_write;
                        r_addrSh <= req_addr;
                        r_dataSh <= req_wdata;
                        r_serOut <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                S_START: begin
                    r_state  <= S_ADDR;
                    r_serOut <= r_addrSh[7];
                    r_addrSh <= {r_addrSh[6:0], 1'b0};
                    r_cnt    <= '0;
                end
                S_ADDR: begin
                    if (r_cnt == 7'd7) begin
                        r_state  <= S_CMD;
                        r_serOut <= r_write;
                    end else begin
                        r_serOut <= r_addrSh[7];
                        r_addrSh <= {r_addrSh[6:0], 1'b0};
                        r_cnt    <= r_cnt + 7'd1;
                    end
                end
                S_CMD: begin
                    r_state  <= S_DATA;
                    r_serOut <= r_write & r_dataSh[63];
                    r_dataSh <= {r_dataSh[62:0], 1'b0};
                    r_cnt    <= '0;
                end
                S_DATA: begin
                    if (r_cnt == 7'd63) begin
                        r_serOut <= 1'b1;
                        r_cnt    <= '0;
                        if (!r_write && HAS_TAIL) begin
                            r_state <= S_TAIL;
                        end else begin
                            r_state    <= S_GAP;
                            r_rspValid <= 1'b1;
                            r_rspData  <= r_write ? 64'h0 : w_capNext;
                        end
                    end else begin
                        r_serOut <= r_write & r_dataSh[63];
                        r_dataSh <= {r_dataSh[62:0], 1'b0};
                        r_cnt    <= r_cnt + 7'd1;
                    end
                end
                S_TAIL: begin
                    if (r_cnt == 7'(RD_LAT - 1)) begin
                        r_state    <= S_GAP;
                        r_rspValid <= 1'b1;
                        r_rspData  <= w_capNext;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == 7'(IDLE_GAP - 1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_serOut <= 1'b1;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_percept_bus_master.sv
// Scoreboard bench for percept_bus_master: one instance at RD_LAT=0 and one at
// RD_LAT=2, each with a responder model and a frame/response monitor.
module tb_percept_bus_master;

    typedef struct {
        int          d;
        logic [74:0] bits;
    } frameExp_t;

    typedef struct {
        int          d;
        logic [63:0] data;
    } rspExp_t;

    logic        clk;
    logic        nRst;
    logic        reqValidW [2];
    logic        reqReadyW [2];
    logic        reqWrite;
    logic [7:0]  reqAddr;
    logic [63:0] reqWdata;
    logic        rspValidW [2];
    logic [63:0] rspRdataW [2];
    logic        busyW     [2];
    logic        serOutW   [2];
    logic        serInW    [2];

    int          assertCount = 0;
    int          failCount   = 0;
    int          cyc         = 0;

    frameExp_t   frameQ[$];
    rspExp_t     rspQ[$];

    int          idx       [2] = '{-1, -1};
    bit          inFrame   [2] = '{1'b0, 1'b0};
    logic [74:0] frameBits [2];
    logic        cmdBit    [2] = '{1'b1, 1'b1};
    logic [63:0] respWord  [2] = '{64'h0, 64'h0};
    bit          noiseEn   = 1'b0;

    percept_bus_master #(.RD_LAT(0), .IDLE_GAP(2)) dutA (
        .clk       (clk),
        .nRst      (nRst),
        .req_valid (reqValidW[0]),
        .req_ready (reqReadyW[0]),
        .req_write (reqWrite),
        .req_addr  (reqAddr),
        .req_wdata (reqWdata),
        .rsp_valid (rspValidW[0]),
        .rsp_rdata (rspRdataW[0]),
        .busy      (busyW[0]),
        .ser_out   (serOutW[0]),
        .ser_in    (serInW[0])
    );

    percept_bus_master #(.RD_LAT(2), .IDLE_GAP(2)) dutB (
        .clk       (clk),
        .nRst      (nRst),
        .req_valid (reqValidW[1]),
        .req_ready (reqReadyW[1]),
        .req_write (reqWrite),
        .req_addr  (reqAddr),
        .req_wdata (reqWdata),
        .rsp_valid (rspValidW[1]),
        .rsp_rdata (rspRdataW[1]),
        .busy      (busyW[1]),
        .ser_out   (serOutW[1]),
        .ser_in    (serInW[1])
    );

    // 50 MHz clock and a free-running cycle counter for spacing checks
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something wedges the stimulus
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int latOf(input int d);
        return (d == 1) ? 2 : 0;
    endfunction

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkFrame(input int d, input logic [74:0] bits);
        frameExp_t e;
        if (frameQ.size() == 0) begin
            checkOutput($sformatf("dut%0d frame without pending expectation", d), 0, 1);
        end else begin
            e = frameQ.pop_front();
            checkOutput($sformatf("dut%0d ser_out frame", d), {5'h0, bits}, {5'h0, e.bits});
        end
    endtask

    task automatic checkRsp(input int d);
        rspExp_t e;
        if (rspQ.size() == 0) begin
            checkOutput($sformatf("dut%0d rsp_valid without pending expectation", d), 0, 1);
        end else begin
            e = rspQ.pop_front();
            checkOutput($sformatf("dut%0d rsp_rdata", d), {16'h0, rspRdataW[d]}, {16'h0, e.data});
            checkOutput($sformatf("dut%0d rsp_valid cycle", d), 80'(idx[d]), 80'(74 + latOf(d)));
        end
    endtask

    // Monitor and responder: tracks each frame from its start bit, compares the
    // serial frame and the response against the scoreboard, and drives ser_in
    // with the addressed slave's reply delayed by that instance's RD_LAT.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!nRst) begin
                inFrame[d] = 1'b0;
                idx[d]     = -1;
                serInW[d]  = 1'b0;
            end else begin
                int k;
                if (idx[d] >= 0) idx[d] = idx[d] + 1;
                if (!inFrame[d] && serOutW[d] === 1'b0) begin
                    inFrame[d]   = 1'b1;
                    idx[d]       = 0;
                    frameBits[d] = '0;
                end
                if (inFrame[d]) begin
                    frameBits[d] = {frameBits[d][73:0], serOutW[d]};
                    if (idx[d] == 9) cmdBit[d] = serOutW[d];
                    if (idx[d] == 74) begin
                        inFrame[d] = 1'b0;
                        checkFrame(d, frameBits[d]);
                    end
                end
                if (rspValidW[d] === 1'b1) begin
                    checkRsp(d);
                    idx[d] = -1;
                end else if (idx[d] > 80 + latOf(d)) begin
                    checkOutput($sformatf("dut%0d rsp_valid timeout at cycle", d), 80'(idx[d]), 80'(74 + latOf(d)));
                    idx[d] = -1;
                end
                k = idx[d] - 10 - latOf(d);
                if (idx[d] >= 0 && cmdBit[d] == 1'b0 && k >= 0 && k < 64)
                    serInW[d] = respWord[d][63 - k];
                else
                    serInW[d] = noiseEn ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    task automatic pushExpect(input int d, input bit wr, input logic [7:0] addr,
                              input logic [63:0] wdata, input logic [63:0] rword);
        frameExp_t f;
        rspExp_t   r;
        f.d    = d;
        f.bits = {1'b0, addr, wr, (wr ? wdata : 64'h0), 1'b1};
        r.d    = d;
        r.data = wr ? 64'h0 : rword;
        frameQ.push_back(f);
        rspQ.push_back(r);
    endtask

    task automatic waitReady(input int d);
        bit got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (reqReadyW[d] === 1'b1) got = 1'b1;
        end
        checkOutput($sformatf("dut%0d req_ready reached", d), {79'h0, got}, 80'h1);
    endtask

    task automatic waitIdle(input int d);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (frameQ.size() == 0 && rspQ.size() == 0 && reqReadyW[d] === 1'b1) done = 1'b1;
        end
        checkOutput($sformatf("dut%0d scoreboard drained", d), {79'h0, done}, 80'h1);
    endtask

    // Issues one request when the instance is ready, then scrambles the
    // request bus to show the frame depends only on the latched values.
    task automatic applyStimulus(input int d, input bit wr, input logic [7:0] addr,
                                 input logic [63:0] wdata, input logic [63:0] rword);
        respWord[d] = rword;
        pushExpect(d, wr, addr, wdata, rword);
        waitReady(d);
        reqValidW[d] = 1'b1;
        reqWrite     = wr;
        reqAddr      = addr;
        reqWdata     = wdata;
        @(negedge clk);
        reqValidW[d] = 1'b0;
        reqWrite     = 1'($urandom_range(0, 1));
        reqAddr      = 8'($urandom);
        reqWdata     = {$urandom, $urandom};
    endtask

    initial begin
        int t1;
        int t2;
        nRst         = 1'b1;
        reqValidW[0] = 1'b0;
        reqValidW[1] = 1'b0;
        reqWrite     = 1'b0;
        reqAddr      = '0;
        reqWdata     = '0;
        #2 nRst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("dut%0d reset ser_out", d), {79'h0, serOutW[d]}, 80'h1);
            checkOutput($sformatf("dut%0d reset req_ready", d), {79'h0, reqReadyW[d]}, 80'h1);
            checkOutput($sformatf("dut%0d reset busy", d), {79'h0, busyW[d]}, 80'h0);
            checkOutput($sformatf("dut%0d reset rsp_valid", d), {79'h0, rspValidW[d]}, 80'h0);
            checkOutput($sformatf("dut%0d reset rsp_rdata", d), {16'h0, rspRdataW[d]}, 80'h0);
        end
        repeat (3) @(negedge clk);
        nRst = 1'b1;

        $display("[TB] write 0x10 / AAAA... and reads of 0xAA");
        applyStimulus(0, 1'b1, 8'h10, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0);
        waitIdle(0);
        applyStimulus(0, 1'b0, 8'hAA, 64'hFFFF_0000_FFFF_0000, 64'hDEAD_BEEF_0123_4567);
        waitIdle(0);
        noiseEn = 1'b1;
        applyStimulus(1, 1'b0, 8'hAA, 64'h1234_5678_9ABC_DEF0, 64'hDEAD_BEEF_0123_4567);
        waitIdle(1);
        noiseEn = 1'b0;

        // Back-to-back acceptance with req_valid held and the bus changed
        // straight after the first accept.
        $display("[TB] held req_valid back-to-back writes");
        pushExpect(0, 1'b1, 8'h01, 64'h0101_0101_0101_0101, 64'h0);
        waitReady(0);
        reqValidW[0] = 1'b1;
        reqWrite     = 1'b1;
        reqAddr      = 8'h01;
        reqWdata     = 64'h0101_0101_0101_0101;
        @(negedge clk);
        t1       = cyc;
        reqAddr  = 8'h5C;
        reqWdata = 64'h1234_5678_9ABC_DEF0;
        pushExpect(0, 1'b1, 8'h5C, 64'h1234_5678_9ABC_DEF0, 64'h0);
        t2 = t1;
        for (int i = 0; i < 200 && t2 == t1; i++) begin
            @(negedge clk);
            if (reqReadyW[0] === 1'b1) begin
                @(negedge clk);
                t2 = cyc;
            end
        end
        reqValidW[0] = 1'b0;
        checkOutput("accept spacing", 80'(t2 - t1), 80'd77);
        checkOutput("busy after second accept", {79'h0, busyW[0]}, 80'h1);
        waitIdle(0);

        // Reset during data bit 30 of a write whose bit 30 is 0
        $display("[TB] reset mid-frame");
        waitReady(0);
        reqValidW[0] = 1'b1;
        reqWrite     = 1'b1;
        reqAddr      = 8'h3C;
        reqWdata     = 64'hF0F0_F0F0_0000_FFFF;
        @(negedge clk);
        reqValidW[0] = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("ser_out at data bit 30", {79'h0, serOutW[0]}, 80'h0);
        nRst = 1'b0;
        #1;
        checkOutput("mid-frame reset ser_out", {79'h0, serOutW[0]}, 80'h1);
        checkOutput("mid-frame reset busy", {79'h0, busyW[0]}, 80'h0);
        checkOutput("mid-frame reset rsp_valid", {79'h0, rspValidW[0]}, 80'h0);
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        applyStimulus(0, 1'b1, 8'h5A, 64'h0123_4567_89AB_CDEF, 64'h0);
        waitIdle(0);

        // Random ser_in activity during a write and while idle
        $display("[TB] ser_in noise");
        noiseEn = 1'b1;
        respWord[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        applyStimulus(0, 1'b1, 8'h77, 64'h0F0F_0F0F_3C3C_3C3C, 64'h0);
        waitIdle(0);
        repeat (20) @(negedge clk);
        noiseEn = 1'b0;
        checkOutput("rsp_rdata after noise", {16'h0, rspRdataW[0]}, 80'h0);
        checkOutput("frame queue empty", 80'(frameQ.size()), 80'h0);
        checkOutput("response queue empty", 80'(rspQ.size()), 80'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
